// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;
  localparam int DEF_WIDTH = 16;
  localparam logic [DEF_WIDTH-1:0] SAT_Q = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;
endpackage

// File: rtl/seq_divider_32by16_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
interface seq_divider_32by16_if #(parameter int WIDTH = div_pkg::DEF_WIDTH);
  logic               start;
  logic [2*WIDTH-1:0] dividend;
  logic [WIDTH-1:0]   divisor;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]   remainder;
  logic               dbz;
  logic               ovf;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, dbz, ovf
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, dbz, ovf
  );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial subtract.
module div_step #(parameter int WIDTH = 16) (
  input  logic [WIDTH-1:0] r,
  input  logic             qmsb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_nxt,
  output logic             qbit
);
  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] diff;

  assign t    = {r, qmsb};
  assign qbit = (t >= {1'b0, d});
  // When qbit is set the true difference is < d, so the low WIDTH bits are exact.
  assign diff  = t[WIDTH-1:0] - d;
  assign r_nxt = qbit ? diff : t[WIDTH-1:0];
endmodule

// File: rtl/seq_divider_32by16.sv
// 2W/W iterative restoring divider, one quotient bit per clock, with dbz/ovf traps.
module seq_divider_32by16
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input logic               clk,
  input logic               rst,
  seq_divider_32by16_if.slave bus
);
  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  // Partial remainder stays below the divisor, so its extra top bit is always zero.
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvs;
  logic             busy_q, done_q, dbz_q, ovf_q;
  logic [WIDTH-1:0] quo_q, rem_q;

  logic [WIDTH-1:0] r_nxt;
  logic             qbit;
  logic [WIDTH-1:0] hi, lo;

  assign hi = bus.dividend[2*WIDTH-1:WIDTH];
  assign lo = bus.dividend[WIDTH-1:0];

  div_step #(.WIDTH(WIDTH)) u_step (
    .r    (r),
    .qmsb (q[WIDTH-1]),
    .d    (dvs),
    .r_nxt(r_nxt),
    .qbit (qbit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      r      <= '0;
      q      <= '0;
      dvs    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      ovf_q  <= 1'b0;
      quo_q  <= '0;
      rem_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            dvs   <= bus.divisor;
            r     <= hi;
            q     <= lo;
            cnt   <= '0;
            dbz_q <= 1'b0;
            ovf_q <= 1'b0;
            if (bus.divisor == '0) begin
              dbz_q  <= 1'b1;
              quo_q  <= WIDTH'(SAT_Q);
              rem_q  <= lo;
              done_q <= 1'b1;
              state  <= DONE;
            end else if (hi >= bus.divisor) begin
              ovf_q  <= 1'b1;
              quo_q  <= WIDTH'(SAT_Q);
              rem_q  <= '0;
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              busy_q <= 1'b1;
              state  <= CALC;
            end
          end
        end
        CALC: begin
          r   <= r_nxt;
          q   <= {q[WIDTH-2:0], qbit};
          cnt <= cnt + 1'b1;
          // Results publish only on the final iteration.
          if (cnt == CNT_W'(WIDTH - 1)) begin
            quo_q  <= {q[WIDTH-2:0], qbit};
            rem_q  <= r_nxt;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dbz       = dbz_q;
  assign bus.ovf       = ovf_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
endmodule

// File: tb/tb_seq_divider_32by16.sv
// Directed and randomized checks of seq_divider_32by16 against an arithmetic model.
module tb_seq_divider_32by16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  seq_divider_32by16_if #(.WIDTH(16)) bus ();

  seq_divider_32by16 #(.WIDTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division with the trap rules applied first.
  task automatic model(input logic [31:0] dd, input logic [15:0] ds,
                       output logic [15:0] eq, output logic [15:0] er,
                       output logic edbz, output logic eovf);
    logic [31:0] qq;
    edbz = 1'b0; eovf = 1'b0;
    if (ds == 16'd0) begin
      edbz = 1'b1; eq = 16'hFFFF; er = dd[15:0];
    end else if ({16'd0, dd[31:16]} >= {16'd0, ds}) begin
      eovf = 1'b1; eq = 16'hFFFF; er = 16'd0;
    end else begin
      qq = dd / {16'd0, ds};
      eq = qq[15:0];
      er = 16'(dd % {16'd0, ds});
    end
  endtask

  task automatic check_outs(input string tag, input logic [15:0] eq, input logic [15:0] er,
                            input logic edbz, input logic eovf);
    chk({tag, ".quo"}, 32'(bus.quotient), 32'(eq));
    chk({tag, ".rem"}, 32'(bus.remainder), 32'(er));
    chk({tag, ".dbz"}, 32'(bus.dbz), 32'(edbz));
    chk({tag, ".ovf"}, 32'(bus.ovf), 32'(eovf));
  endtask

  // Issues one start, optionally injects ignored starts during CALC and DONE,
  // and checks latency, busy length, done width and results.
  task automatic run_op(input string tag, input logic [31:0] dd, input logic [15:0] ds,
                        input bit noise);
    logic [15:0] eq, er;
    logic        edbz, eovf;
    int          k, busy_cnt, lat;
    bit          got;
    model(dd, ds, eq, er, edbz, eovf);
    lat = (edbz || eovf) ? 1 : 17;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = dd; bus.divisor = ds;
    @(posedge clk);
    k = 0; busy_cnt = 0; got = 1'b0;
    while (k < 40 && !got) begin
      @(negedge clk);
      k++;
      bus.start = 1'b0;
      bus.dividend = dd; bus.divisor = ds;
      if (noise && k == 5) begin
        bus.start = 1'b1; bus.dividend = $urandom; bus.divisor = 16'($urandom_range(1, 65535));
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) got = 1'b1;
    end
    chk({tag, ".lat"}, got ? 32'(k) : 32'hDEAD_0000, 32'(lat));
    chk({tag, ".busy"}, 32'(busy_cnt), (edbz || eovf) ? 32'd0 : 32'd16);
    check_outs(tag, eq, er, edbz, eovf);
    if (noise) begin
      bus.start = 1'b1; bus.dividend = 32'h0000_0007; bus.divisor = 16'd2;
    end
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, ".done1"}, 32'(bus.done), 32'd0);
    if (noise) begin
      repeat (3) @(negedge clk);
      chk({tag, ".ign.busy"}, 32'(bus.busy), 32'd0);
      check_outs({tag, ".ign"}, eq, er, edbz, eovf);
    end
  endtask

  initial begin
    logic [15:0] ds, hi, lo, eq, er;
    logic        edbz, eovf;
    int          sel;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    #1;
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.done", 32'(bus.done), 32'd0);
    check_outs("rst", 16'd0, 16'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op("exact", 32'h0111_3111, 16'h1101, 1'b0);
    run_op("remd",  32'h0111_3116, 16'h1101, 1'b0);
    run_op("max",   32'hFFFE_0001, 16'hFFFF, 1'b0);
    run_op("div1",  32'h0000_FFFE, 16'h0001, 1'b0);
    run_op("dbz",   32'h1234_5678, 16'h0000, 1'b0);
    run_op("ovf",   32'h1101_0000, 16'h1101, 1'b0);
    run_op("noise", 32'h0111_3116, 16'h1101, 1'b1);
    run_op("ovfnz", 32'hABCD_0001, 16'h0003, 1'b1);

    // Outputs hold through idle cycles.
    repeat (5) @(negedge clk);
    check_outs("hold", 16'hFFFF, 16'd0, 1'b0, 1'b1);

    // Reset part-way through an operation.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 32'h0111_3111; bus.divisor = 16'h1101;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid.busy_pre", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid.busy", 32'(bus.busy), 32'd0);
    chk("mid.done", 32'(bus.done), 32'd0);
    check_outs("mid", 16'd0, 16'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    sel = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done || bus.busy) sel++;
    end
    chk("mid.quiet", 32'(sel), 32'd0);
    run_op("after", 32'h0111_3111, 16'h1101, 1'b0);

    // Randomized operands, mostly legal with occasional traps.
    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 9);
      ds  = 16'($urandom_range(1, 65535));
      lo  = 16'($urandom);
      if (sel == 0) begin
        ds = 16'd0; hi = 16'($urandom);
      end else if (sel == 1) begin
        hi = 16'($urandom_range(int'(ds), 65535));
      end else begin
        hi = 16'($urandom_range(0, int'(ds) - 1));
      end
      run_op("rand", {hi, lo}, ds, (sel == 2));
      model({hi, lo}, ds, eq, er, edbz, eovf);
      if (!edbz && !eovf)
        chk("rand.inv", 32'(bus.quotient) * 32'(ds) + 32'(bus.remainder), {hi, lo});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
